cpu_bus_responder: RTL and testbench

- Target side of the 65C02 core's memory bus.
- Decodes AB/WE/DO from the core and steers each access to one of four regions:
  - zero-wait synchronous RAM/ROM port
  - local interrupt/timer register file
  - external slow-device handshake port with wait-state insertion
- Generates the core's rdy, irq and nmi inputs and supplies the read data that appears on the core's DB.

---
 rtl/bus_pkg.sv | 31 +++
 rtl/bus_timer.sv | 41 ++++
 rtl/cpu_bus_responder.sv | 171 +++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 65C02 bus responder: address map, register
// offsets, status bit positions and the state/region encodings.
package bus_pkg;

    localparam logic [15:0] RAM_LIMIT = 16'hBFFF;
    localparam logic [15:0] EXT_BASE  = 16'hC100;
    localparam logic [15:0] ROM_BASE  = 16'hE000;

    localparam logic [7:0] REG_STATUS   = 8'h00;
    localparam logic [7:0] REG_MASK     = 8'h01;
    localparam logic [7:0] REG_NMI_TRIG = 8'h02;
    localparam logic [7:0] REG_TMR_LO   = 8'h03;
    localparam logic [7:0] REG_TMR_HI   = 8'h04;

    localparam int ST_EXT_TIMEOUT = 0;
    localparam int ST_TIMER       = 1;

    typedef enum logic [1:0] {EXT_IDLE, EXT_REQ, EXT_DONE} ext_state_t;
    typedef enum logic [1:0] {RGN_RAM, RGN_ROM, RGN_REG, RGN_EXT} region_t;

    // C000-C0FF is the only REG page; everything between it and ROM is EXT.
    function automatic region_t decode_region(input logic [15:0] addr);
        region_t r;
        if (addr <= RAM_LIMIT)     r = RGN_RAM;
        else if (addr >= ROM_BASE) r = RGN_ROM;
        else if (addr >= EXT_BASE) r = RGN_EXT;
        else                       r = RGN_REG;
        return r;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Reloadable down-counter: ticks once every reload+1 cycles, idle while
// reload is zero. Writing either reload byte restarts the count.
module bus_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [7:0]  wdata,
    output logic [15:0] reload,
    output logic        tick
);

    logic [15:0] count;
    logic [15:0] reload_next;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        reload_next = reload;
        if (we_lo) reload_next[7:0]  = wdata;
        if (we_hi) reload_next[15:8] = wdata;
    end

    assign tick = (reload != 16'h0000) && (count == 16'h0000);

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload <= 16'h0000;
            count  <= 16'h0000;
        end else begin
            reload <= reload_next;
            if (we_lo || we_hi)
                count <= reload_next;
            else if (tick)
                count <= reload;
            else if (reload != 16'h0000)
                count <= count - 16'd1;
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-bus target for the 65C02 core: region decode, zero-wait RAM/ROM and
// register access, and a wait-state handshake to slow external devices.
module cpu_bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 64,
    parameter int unsigned NMI_LEN  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        rdy,
    output logic        irq,
    output logic        nmi,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        ext_req,
    output logic        ext_we,
    output logic [12:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
);

    localparam int NMI_W = $clog2(NMI_LEN + 1);

    region_t          region, sel_q;
    ext_state_t       state, state_next;
    logic             ext_start, ext_ack_evt, ext_timeout_evt;
    logic [7:0]       wait_cnt, ext_data_q;
    logic [7:0]       reg_off, reg_rdata, reg_rdata_q;
    logic             reg_we;
    logic [1:0]       status, mask, status_set, status_clr;
    logic [NMI_W-1:0] nmi_cnt;
    logic [15:0]      reload;
    logic             tick;

    assign region    = decode_region(AB);
    assign reg_off   = AB[7:0];
    assign mem_addr  = AB;
    assign mem_wdata = DO;
    assign mem_we    = WE && rdy && (region == RGN_RAM);
    assign reg_we    = WE && rdy && (region == RGN_REG);
    assign nmi       = (nmi_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EXT_IDLE;
        else       state <= state_next;
    end

    // rdy is held high while reset is asserted, whatever AB happens to be.
    always_comb begin
        state_next      = state;
        rdy             = 1'b1;
        ext_start       = 1'b0;
        ext_ack_evt     = 1'b0;
        ext_timeout_evt = 1'b0;
        unique case (state)
            EXT_IDLE: if (region == RGN_EXT && !reset) begin
                rdy        = 1'b0;
                ext_start  = 1'b1;
                state_next = EXT_REQ;
            end
            EXT_REQ: begin
                rdy = 1'b0;
                if (ext_ack) begin
                    ext_ack_evt = 1'b1;
                    state_next  = EXT_DONE;
                end else if (wait_cnt == 8'(WAIT_MAX - 1)) begin
                    ext_timeout_evt = 1'b1;
                    state_next      = EXT_DONE;
                end
            end
            EXT_DONE: state_next = EXT_IDLE;
            default:  state_next = EXT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_req    <= 1'b0;
            ext_we     <= 1'b0;
            wait_cnt   <= 8'd0;
            ext_data_q <= 8'h00;
        end else begin
            if (ext_start) begin
                ext_req  <= 1'b1;
                ext_we   <= WE;
                wait_cnt <= 8'd0;
            end else if (ext_ack_evt || ext_timeout_evt) begin
                ext_req <= 1'b0;
                ext_we  <= 1'b0;
            end
            if (state == EXT_REQ) wait_cnt <= wait_cnt + 8'd1;
            if (ext_ack_evt)          ext_data_q <= ext_rdata;
            else if (ext_timeout_evt) ext_data_q <= 8'hFF;
        end
    end

    // NOTE: request address/data are pure datapath, always loaded before ext_req rises, so they carry no reset.
    always_ff @(posedge clk) begin
        if (ext_start) begin
            ext_addr  <= AB[12:0];
            ext_wdata <= DO;
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_off)
            REG_STATUS: reg_rdata = {6'b0, status};
            REG_MASK:   reg_rdata = {6'b0, mask};
            REG_TMR_LO: reg_rdata = reload[7:0];
            REG_TMR_HI: reg_rdata = reload[15:8];
            default:    reg_rdata = 8'h00;
        endcase
    end

    always_comb begin
        status_set                 = 2'b00;
        status_set[ST_EXT_TIMEOUT] = ext_timeout_evt;
        status_set[ST_TIMER]       = tick;
        status_clr = (reg_we && reg_off == REG_STATUS) ? DO[1:0] : 2'b00;
    end

    // Set terms are OR-ed in after the clear so a same-cycle event survives W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status      <= 2'b00;
            mask        <= 2'b00;
            nmi_cnt     <= '0;
            irq         <= 1'b0;
            reg_rdata_q <= 8'h00;
            sel_q       <= RGN_REG;
        end else begin
            status <= (status & ~status_clr) | status_set;
            if (reg_we && reg_off == REG_MASK) mask <= DO[1:0];
            if (reg_we && reg_off == REG_NMI_TRIG) nmi_cnt <= NMI_W'(NMI_LEN);
            else if (nmi_cnt != '0)                nmi_cnt <= nmi_cnt - NMI_W'(1);
            irq         <= |(status & mask);
            reg_rdata_q <= reg_rdata;
            sel_q       <= region;
        end
    end

    always_comb begin
        DI = 8'h00;
        case (sel_q)
            RGN_RAM, RGN_ROM: DI = mem_rdata;
            RGN_REG:          DI = reg_rdata_q;
            RGN_EXT:          DI = ext_data_q;
            default:          DI = 8'h00;
        endcase
    end

    bus_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .we_lo  (reg_we && reg_off == REG_TMR_LO),
        .we_hi  (reg_we && reg_off == REG_TMR_HI),
        .wdata  (DO),
        .reload (reload),
        .tick   (tick)
    );

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: a vector table for zero-wait accesses
// plus hand-written sequences for wait states, timeout, timer, NMI and reset.
module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI;
    logic        rdy, irq, nmi;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        ext_req, ext_we;
    logic [12:0] ext_addr;
    logic [7:0]  ext_wdata, ext_rdata;
    logic        ext_ack;

    int n_checks = 0;
    int n_errors = 0;

    cpu_bus_responder #(.WAIT_MAX(64), .NMI_LEN(2)) dut (
        .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE), .DI(DI),
        .rdy(rdy), .irq(irq), .nmi(nmi),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ab;
        logic [7:0]  dout;
        logic        we;
        logic [7:0]  rdata;
        logic        exp_mem_we;
        logic [7:0]  exp_di;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        AB = a; DO = d; WE = 1'b1;
        next_cycle();
        AB = 16'h0000; DO = 8'h00; WE = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        AB = a; WE = 1'b0;
        next_cycle();
        AB = 16'h0000;
        @(negedge clk);
        check(name, DI, exp);
        next_cycle();
    endtask

    task automatic ext_access(input string name, input logic [15:0] ab, input logic we_i,
                              input logic [7:0] d, input int ack_at, input logic [7:0] rdata,
                              input int exp_low, input int exp_reqs, input logic [7:0] exp_di);
        int seen, low, reqs;
        bit done, captured;
        logic [12:0] cap_addr;
        logic        cap_we;
        logic [7:0]  cap_wdata;
        seen = 0; low = 0; reqs = 0; done = 1'b0; captured = 1'b0;
        cap_addr = '0; cap_we = 1'b0; cap_wdata = '0;
        AB = ab; WE = we_i; DO = d; ext_rdata = rdata;
        for (int c = 0; c < 300 && !done; c++) begin
            ext_ack = 1'b0;
            if (ext_req) begin
                seen++;
                ext_ack = (seen == ack_at);
            end
            @(negedge clk);
            if (ext_req) begin
                reqs++;
                if (!captured) begin
                    captured = 1'b1;
                    cap_addr = ext_addr; cap_we = ext_we; cap_wdata = ext_wdata;
                end
            end
            if (rdy) done = 1'b1;
            else     low++;
            next_cycle();
        end
        ext_ack = 1'b0; AB = 16'h0000; WE = 1'b0; DO = 8'h00;
        check({name, "_done"}, 16'(done), 16'd1);
        check({name, "_rdy_low"}, 16'(low), 16'(exp_low));
        check({name, "_req_cycles"}, 16'(reqs), 16'(exp_reqs));
        check({name, "_addr"}, 16'(cap_addr), 16'(ab[12:0]));
        check({name, "_we"}, 16'(cap_we), 16'(we_i));
        if (we_i) check({name, "_wdata"}, 16'(cap_wdata), 16'(d));
        @(negedge clk);
        check({name, "_di"}, 16'(DI), 16'(exp_di));
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        //            ab        do     we    rdata  mwe   di
        vecs[0]  = '{16'h1234, 8'h00, 1'b0, 8'h5A, 1'b0, 8'h5A};
        vecs[1]  = '{16'hE010, 8'h77, 1'b1, 8'h3C, 1'b0, 8'h3C};
        vecs[2]  = '{16'h0200, 8'h77, 1'b1, 8'h11, 1'b1, 8'h11};
        vecs[3]  = '{16'hBFFF, 8'h00, 1'b0, 8'hC3, 1'b0, 8'hC3};
        vecs[4]  = '{16'hC001, 8'h00, 1'b0, 8'h99, 1'b0, 8'h00};
        vecs[5]  = '{16'hC001, 8'hFF, 1'b1, 8'h99, 1'b0, 8'h00};
        vecs[6]  = '{16'hC001, 8'h00, 1'b0, 8'h99, 1'b0, 8'h03};
        vecs[7]  = '{16'hC002, 8'h00, 1'b0, 8'h99, 1'b0, 8'h00};
        vecs[8]  = '{16'hC005, 8'hAA, 1'b1, 8'h99, 1'b0, 8'h00};
        vecs[9]  = '{16'hC005, 8'h00, 1'b0, 8'h99, 1'b0, 8'h00};
        vecs[10] = '{16'hC004, 8'h12, 1'b1, 8'h99, 1'b0, 8'h00};
        vecs[11] = '{16'hC004, 8'h00, 1'b0, 8'h99, 1'b0, 8'h12};
        vecs[12] = '{16'hC003, 8'h34, 1'b1, 8'h99, 1'b0, 8'h00};
        vecs[13] = '{16'hC003, 8'h00, 1'b0, 8'h99, 1'b0, 8'h34};
        vecs[14] = '{16'hC004, 8'h00, 1'b1, 8'h99, 1'b0, 8'h12};
        vecs[15] = '{16'hC003, 8'h00, 1'b1, 8'h99, 1'b0, 8'h34};
        vecs[16] = '{16'hC001, 8'h00, 1'b1, 8'h99, 1'b0, 8'h03};
        vecs[17] = '{16'hFFFF, 8'h00, 1'b0, 8'h6B, 1'b0, 8'h6B};
        vecs[18] = '{16'hC0FF, 8'h00, 1'b0, 8'h44, 1'b0, 8'h00};
        vecs[19] = '{16'hE000, 8'h55, 1'b1, 8'h21, 1'b0, 8'h21};

        reset = 1'b1; AB = 16'h0000; DO = 8'h00; WE = 1'b0;
        mem_rdata = 8'h00; ext_rdata = 8'h00; ext_ack = 1'b0;
        #3;
        check("rst_rdy", 16'(rdy), 16'd1);
        check("rst_irq", 16'(irq), 16'd0);
        check("rst_nmi", 16'(nmi), 16'd0);
        check("rst_ext_req", 16'(ext_req), 16'd0);
        check("rst_ext_we", 16'(ext_we), 16'd0);
        check("rst_di", 16'(DI), 16'h00);
        @(posedge clk);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            AB = vecs[i].ab; DO = vecs[i].dout; WE = vecs[i].we;
            @(negedge clk);
            check($sformatf("v%0d_rdy", i), 16'(rdy), 16'd1);
            check($sformatf("v%0d_mem_we", i), 16'(mem_we), 16'(vecs[i].exp_mem_we));
            if (vecs[i].exp_mem_we) check($sformatf("v%0d_wdata", i), 16'(mem_wdata), 16'(vecs[i].dout));
            next_cycle();
            AB = 16'h0000; WE = 1'b0; DO = 8'h00; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("v%0d_di", i), 16'(DI), 16'(vecs[i].exp_di));
            next_cycle();
        end

        // Wait-state read: ack in the 3rd REQ cycle.
        ext_access("ext_rd", 16'hC100, 1'b0, 8'h00, 3, 8'hA5, 4, 3, 8'hA5);

        // Timeout, status bit, irq on mask, W1C.
        ext_access("ext_to", 16'hD000, 1'b0, 8'h00, 0, 8'h00, 65, 64, 8'hFF);
        rd_check("status_to", 16'hC000, 8'h01);
        wr(16'hC001, 8'h01);
        next_cycle();
        @(negedge clk);
        check("irq_to_set", 16'(irq), 16'd1);
        next_cycle();
        wr(16'hC000, 8'h01);
        next_cycle();
        @(negedge clk);
        check("irq_to_clr", 16'(irq), 16'd0);
        next_cycle();

        // Ack coinciding with the timeout cycle: ack wins, no status bit.
        ext_access("ext_ack_to", 16'hD000, 1'b0, 8'h00, 64, 8'h3E, 65, 64, 8'h3E);
        rd_check("status_ack_to", 16'hC000, 8'h00);

        // Timer: reload=4, period 5; W1C on a tick cycle leaves the bit set.
        wr(16'hC001, 8'h02);
        wr(16'hC003, 8'h04);
        for (int k = 1; k <= 17; k++) begin
            AB = 16'h0000; WE = 1'b0; DO = 8'h00;
            if (k == 10 || k == 12) begin AB = 16'hC000; WE = 1'b1; DO = 8'h02; end
            if (k == 11 || k == 13 || k == 16) AB = 16'hC000;
            @(negedge clk);
            if (k == 6)  check("tmr_irq_k6", 16'(irq), 16'd0);
            if (k == 7)  check("tmr_irq_k7", 16'(irq), 16'd1);
            if (k == 12) check("tmr_w1c_tick_di", 16'(DI), 16'h02);
            if (k == 13) check("tmr_irq_k13", 16'(irq), 16'd1);
            if (k == 14) check("tmr_w1c_di", 16'(DI), 16'h00);
            if (k == 14) check("tmr_irq_k14", 16'(irq), 16'd0);
            if (k == 17) check("tmr_reset_di", 16'(DI), 16'h02);
            if (k == 17) check("tmr_irq_k17", 16'(irq), 16'd1);
            next_cycle();
        end
        wr(16'hC003, 8'h00);
        wr(16'hC000, 8'h03);

        // NMI trigger followed by reset in the middle of an ext REQ.
        AB = 16'hC002; WE = 1'b1; DO = 8'h00;
        @(negedge clk);
        check("nmi_c0", 16'(nmi), 16'd0);
        next_cycle();
        AB = 16'hC200; WE = 1'b0;
        @(negedge clk);
        check("nmi_c1", 16'(nmi), 16'd1);
        check("rst_seq_rdy_idle", 16'(rdy), 16'd0);
        next_cycle();
        @(negedge clk);
        check("nmi_c2", 16'(nmi), 16'd1);
        check("rst_seq_req1", 16'(ext_req), 16'd1);
        next_cycle();
        @(negedge clk);
        check("nmi_c3", 16'(nmi), 16'd0);
        check("rst_seq_req2", 16'(ext_req), 16'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_req", 16'(ext_req), 16'd0);
        check("rst_async_rdy", 16'(rdy), 16'd1);
        check("rst_async_di", 16'(DI), 16'h00);
        AB = 16'h0000;
        next_cycle();
        reset = 1'b0;
        ext_access("ext_after_rst", 16'hC300, 1'b1, 8'h5C, 1, 8'h9D, 2, 1, 8'h9D);
        rd_check("mask_after_rst", 16'hC001, 8'h00);

        // NMI retrigger while active restarts the count.
        wr(16'hC002, 8'h00);
        AB = 16'hC002; WE = 1'b1;
        @(negedge clk);
        check("nmi_rt1", 16'(nmi), 16'd1);
        next_cycle();
        AB = 16'h0000; WE = 1'b0;
        @(negedge clk);
        check("nmi_rt2", 16'(nmi), 16'd1);
        next_cycle();
        @(negedge clk);
        check("nmi_rt3", 16'(nmi), 16'd1);
        next_cycle();
        @(negedge clk);
        check("nmi_rt4", 16'(nmi), 16'd0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
